// File: rtl/monolith_bars_seq.sv
// Sequential Bars layer of Monolith-31 over M31.
// A captured state has its first NUM_BARS elements replaced, LANES per cycle,
// by the limb-wise chi-like S-box map. The remaining elements pass through
// bit-exact. The result is held until the downstream handshake.

// One Bars lane: split into 8/8/8/7-bit limbs, S-box each, recompose.
module monolith_bars_lane (
  input  logic [30:0] i_x,
  output logic [30:0] o_y
);
  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] nx, t, z;
    nx = ~x;
    t  = {nx[6:0], nx[7]} & {x[5:0], x[7:6]} & {x[4:0], x[7:5]};
    z  = x ^ t;
    return {z[6:0], z[7]};
  endfunction

  function automatic logic [6:0] sbox7(input logic [6:0] x);
    logic [6:0] nx, t, z;
    nx = ~x;
    t  = {nx[5:0], nx[6]} & {x[4:0], x[6:5]};
    z  = x ^ t;
    return {z[5:0], z[6]};
  endfunction

  // No modular reduction: 0x7FFFFFFF is processed like any other pattern.
  assign o_y = {sbox7(i_x[30:24]), sbox8(i_x[23:16]), sbox8(i_x[15:8]), sbox8(i_x[7:0])};
endmodule

module monolith_bars_seq #(
  parameter int STATE_WIDTH = 16,
  parameter int NUM_BARS    = 8,
  parameter int LANES       = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31*STATE_WIDTH-1:0] in_state,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31*STATE_WIDTH-1:0] out_state
);
  localparam int SAFE_L = (LANES == 0) ? 1 : LANES;
  localparam int N      = (NUM_BARS / SAFE_L < 1) ? 1 : NUM_BARS / SAFE_L;
  localparam int CW     = (N > 1) ? $clog2(N) : 1;

  if (NUM_BARS > STATE_WIDTH || LANES == 0 || (NUM_BARS % SAFE_L) != 0) begin : g_bad_params
    $error("monolith_bars_seq: need NUM_BARS <= STATE_WIDTH, LANES > 0, NUM_BARS %% LANES == 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                             r_fsm, w_fsm_nxt;
  logic [CW-1:0]                      r_cnt;
  logic [STATE_WIDTH-1:0][30:0]       r_state;
  logic [LANES-1:0][30:0]             w_lane_in;
  logic [LANES-1:0][30:0]             w_lane_out;
  logic                               w_last;

  assign w_last    = (r_cnt == CW'(N-1));
  assign out_state = r_state;

  // Lane k works on element r_cnt*LANES+k; select it out of the state.
  always_comb begin
    w_lane_in = '0;
    for (int c = 0; c < N; c++)
      if (r_cnt == CW'(c))
        for (int k = 0; k < LANES; k++)
          w_lane_in[k] = r_state[c*LANES+k];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    monolith_bars_lane u_lane (.i_x(w_lane_in[k]), .o_y(w_lane_out[k]));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // FSM next-state: accept -> N run edges -> hold until out_ready.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (in_valid)  w_fsm_nxt = S_RUN;
      S_RUN:   if (w_last)    w_fsm_nxt = S_DONE;
      S_DONE:  if (out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: never ready while a result is pending, so no accept/emit overlap.
  always_comb begin
    in_ready  = (r_fsm == S_IDLE);
    out_valid = (r_fsm == S_DONE);
  end

  // Datapath: capture in IDLE, rewrite one lane group per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: if (in_valid) begin
          r_state <= in_state;
          r_cnt   <= '0;
        end
        S_RUN: begin
          for (int c = 0; c < N; c++)
            if (r_cnt == CW'(c))
              for (int k = 0; k < LANES; k++)
                r_state[c*LANES+k] <= w_lane_out[k];
          if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_monolith_bars_seq.sv
// Bench for monolith_bars_seq: LANES = 1, 2, 8 instances driven in lockstep,
// results checked against a scoreboard of expected states and latencies.
module tb_monolith_bars_seq;
  localparam int SW = 16;
  localparam int W  = 31*SW;

  logic         clk = 0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_state;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [W-1:0] out_state [3];

  int LAT [3] = '{8, 4, 1};

  always #5 clk = ~clk;

  monolith_bars_seq #(.STATE_WIDTH(SW), .NUM_BARS(8), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_state(in_state),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_state(out_state[0]));
  monolith_bars_seq #(.STATE_WIDTH(SW), .NUM_BARS(8), .LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_state(in_state),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_state(out_state[1]));
  monolith_bars_seq #(.STATE_WIDTH(SW), .NUM_BARS(8), .LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .in_state(in_state),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_state(out_state[2]));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Reference S-box, bit by bit: z[i] = x[i] ^ (~x[i-1] & x[i-2] (& x[i-3])), y = rotl1(z).
  function automatic logic [7:0] m_sbox(input logic [7:0] x, input int w);
    logic [7:0] z, y;
    z = '0; y = '0;
    for (int i = 0; i < w; i++)
      z[i] = x[i] ^ (~x[(i+w-1)%w] & x[(i+w-2)%w] & ((w == 8) ? x[(i+w-3)%w] : 1'b1));
    for (int i = 0; i < w; i++) y[(i+1)%w] = z[i];
    return y;
  endfunction

  function automatic logic [W-1:0] m_bars(input logic [W-1:0] s);
    logic [W-1:0] r;
    logic [30:0]  x, y;
    logic [7:0]   t;
    r = s;
    for (int e = 0; e < 8; e++) begin
      x = s[31*e +: 31];
      y = '0;
      for (int l = 0; l < 3; l++) y[8*l +: 8] = m_sbox(x[8*l +: 8], 8);
      t = m_sbox({1'b0, x[30:24]}, 7);
      y[30:24] = t[6:0];
      r[31*e +: 31] = y;
    end
    return r;
  endfunction

  // Scoreboard: one expected entry per transaction, each instance has its own read pointer.
  logic [W-1:0] exp_q [$];
  int rd [3] = '{0, 0, 0};
  int acc [3] = '{0, 0, 0};
  logic [2:0] pv = '0;
  int cyc = 0;

  // Monitor away from the active edge: latency on out_valid rise, data on handshake.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (in_valid && in_ready[k]) acc[k] = cyc;
      if (out_valid[k] && !pv[k]) chk($sformatf("latency_l%0d", k), W'(cyc - acc[k] - 1), W'(LAT[k]));
      pv[k] = out_valid[k];
      if (out_valid[k] && out_ready) begin
        if (rd[k] < exp_q.size()) chk($sformatf("data_l%0d", k), out_state[k], exp_q[rd[k]]);
        else chk($sformatf("spurious_l%0d", k), 1, 0);
        rd[k]++;
      end
    end
  end

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] e);
    int n = 0;
    while (in_ready !== 3'b111 && n < 200) begin @(posedge clk); #1; n++; end
    if (in_ready !== 3'b111) chk("send_timeout", W'(in_ready), W'(3'b111));
    in_valid = 1; in_state = s;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 200 && !(in_ready === 3'b111 && rd[0] == exp_q.size() &&
                        rd[1] == exp_q.size() && rd[2] == exp_q.size())) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  function automatic logic [W-1:0] rnd_state();
    logic [W-1:0] s;
    for (int e = 0; e < SW; e++) s[31*e +: 31] = 31'($urandom);
    return s;
  endfunction

  initial begin
    logic [W-1:0] s, e, held;
    int n;
    rst_n = 0; in_valid = 0; out_ready = 1; in_state = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(3'b111));
    chk("rst_out_valid", W'(out_valid), 0);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_out_state_l%0d", k), out_state[k], 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // All-zero state.
    send('0, '0);
    drain();

    // Known answer: element 0 = 0x01010101.
    s = '0; s[30:0] = 31'h01010101;
    e = '0; e[30:0] = 31'h0A020202;
    send(s, e);
    drain();

    // Pass-through boundary: element 7 gets Bars, element 8 does not.
    s = '0; s[31*7 +: 31] = 31'h00000080; s[31*8 +: 31] = 31'h12345678;
    e = s;  e[31*7 +: 31] = 31'h00000001;
    send(s, e);
    drain();

    // Backpressure: hold out_ready low in DONE, offer a competing input.
    out_ready = 0;
    s = rnd_state();
    send(s, m_bars(s));
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold_reach_done", W'(out_valid[0]), 1);
    held = out_state[0];
    in_valid = 1; in_state = rnd_state();
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_out_valid", W'(out_valid), W'(3'b111));
      chk("hold_out_state", out_state[0], held);
      chk("hold_in_ready", W'(in_ready), 0);
    end
    in_valid = 0; out_ready = 1;
    drain();

    // Reset during the 4th RUN cycle of the LANES=1 instance.
    s = rnd_state();
    send(s, m_bars(s));
    repeat (3) @(posedge clk);
    #1; rst_n = 0;
    #1;
    chk("midrst_in_ready", W'(in_ready[0]), 1);
    chk("midrst_out_valid", W'(out_valid[0]), 0);
    chk("midrst_out_state", out_state[0], 0);
    for (int k = 0; k < 3; k++) rd[k] = exp_q.size();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    s = rnd_state();
    send(s, m_bars(s));
    drain();

    // Random states, including the all-ones M31 edge value.
    for (int t = 0; t < 6; t++) begin
      s = rnd_state();
      if (t == 0) s[31*3 +: 31] = 31'h7FFFFFFF;
      send(s, m_bars(s));
      drain();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
